// File: rtl/bmc_pkg.sv
// Shared types and helpers for the branch-metric unit: metric width, decision mode
// and maximum sample confidence.
package bmc_pkg;

    typedef enum logic {
        MODE_HARD = 1'b0,
        MODE_SOFT = 1'b1
    } bmc_mode_e;

    localparam int HARD_MAX_CONF = 1;

    // Sum of N samples of SW bits each needs clog2(N) extra bits of headroom.
    function automatic int bmc_mw(input int n, input int sw);
        return sw + $clog2(n);
    endfunction

    function automatic bmc_mode_e bmc_mode(input int sw);
        return (sw > 1) ? MODE_SOFT : MODE_HARD;
    endfunction

    function automatic int max_conf(input int sw);
        return (bmc_mode(sw) == MODE_HARD) ? HARD_MAX_CONF : ((1 << sw) - 1);
    endfunction

endpackage

// File: rtl/bmc_dist.sv
// Per-field sample distances to an expected 0 and an expected 1; an erased
// (depunctured) field is forced to zero distance for both hypotheses.
module bmc_dist
    import bmc_pkg::*;
#(
    parameter int SW = 1
) (
    input  logic [SW-1:0] sample,
    input  logic          erase,
    output logic [SW-1:0] d0,
    output logic [SW-1:0] d1
);

    localparam logic [SW-1:0] MAXC = SW'(max_conf(SW));

    assign d0 = erase ? '0 : sample;
    assign d1 = erase ? '0 : MAXC - sample;

endmodule

// File: rtl/bmc_soft_pipe.sv
// Two-stage branch-metric unit for rate-1/N Viterbi decoding with valid/ready on both
// sides and a frame-position tag. Define BMC_ERASURE_EN to add the in_erase port.
module bmc_soft_pipe
    import bmc_pkg::*;
#(
    parameter int  N         = 2,
    parameter int  SW        = 1,
    parameter int  FRAME_LEN = 64,
    localparam int MW        = bmc_mw(N, SW),
    localparam int NC        = 1 << N
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*SW-1:0]    in_sym,
`ifdef BMC_ERASURE_EN
    input  logic [N-1:0]       in_erase,
`endif
    input  logic               in_sync,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NC*MW-1:0]   out_bm,
    output logic               out_last
);

    localparam int            FW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [FW-1:0] LAST_IDX = FW'(FRAME_LEN - 1);

    logic [N-1:0] erase;
`ifdef BMC_ERASURE_EN
    assign erase = in_erase;
`else
    assign erase = '0;
`endif

    logic [N-1:0][SW-1:0] dist0, dist1;

    for (genvar j = 0; j < N; j++) begin : g_dist
        bmc_dist #(.SW(SW)) u_dist (
            .sample (in_sym[j*SW +: SW]),
            .erase  (erase[j]),
            .d0     (dist0[j]),
            .d1     (dist1[j])
        );
    end

    logic                  s1_valid_q, s1_valid_d;
    logic [N-1:0][SW-1:0]  s1_d0_q, s1_d0_d;
    logic [N-1:0][SW-1:0]  s1_d1_q, s1_d1_d;
    logic                  s1_last_q, s1_last_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [NC-1:0][MW-1:0] s2_bm_q, s2_bm_d;
    logic                  s2_last_q, s2_last_d;
    logic [FW-1:0]         fcnt_q, fcnt_d;

    logic                  s1_load, s2_load, accept, idx_last;
    logic [FW-1:0]         idx;
    logic [NC-1:0][MW-1:0] bm_sum;
    logic [MW-1:0]         acc;

    always_comb begin
        s2_load  = !s2_valid_q || out_ready;
        s1_load  = !s1_valid_q || s2_load;
        accept   = in_valid && s1_load;
        idx      = in_sync ? '0 : fcnt_q;
        idx_last = (idx == LAST_IDX);

        fcnt_d = fcnt_q;
        if (accept) begin
            fcnt_d = idx_last ? '0 : idx + FW'(1);
        end

        // Stage 1 holds its contents unless it is loading a freshly accepted symbol.
        s1_valid_d = s1_load ? in_valid : s1_valid_q;
        s1_d0_d    = accept ? dist0 : s1_d0_q;
        s1_d1_d    = accept ? dist1 : s1_d1_q;
        s1_last_d  = accept ? idx_last : s1_last_q;

        // BM[c] picks d(j,1) where codeword bit c[j] is 1, d(j,0) otherwise.
        acc    = '0;
        bm_sum = '0;
        for (int c = 0; c < NC; c++) begin
            acc = '0;
            for (int j = 0; j < N; j++) begin
                if (((c >> j) & 1) != 0) acc = acc + MW'(s1_d1_q[j]);
                else                     acc = acc + MW'(s1_d0_q[j]);
            end
            bm_sum[c] = acc;
        end

        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        s2_bm_d    = (s2_load && s1_valid_q) ? bm_sum : s2_bm_q;
        s2_last_d  = (s2_load && s1_valid_q) ? s1_last_q : s2_last_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_d0_q    <= '0;
            s1_d1_q    <= '0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_bm_q    <= '0;
            s2_last_q  <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_d0_q    <= s1_d0_d;
            s1_d1_q    <= s1_d1_d;
            s1_last_q  <= s1_last_d;
            s2_valid_q <= s2_valid_d;
            s2_bm_q    <= s2_bm_d;
            s2_last_q  <= s2_last_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign in_ready  = s1_load;
    assign out_valid = s2_valid_q;
    assign out_bm    = s2_bm_q;
    assign out_last  = s2_last_q;

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Directed bench for bmc_soft_pipe: a hard-decision instance (N=2,SW=1) and a
// soft instance (N=2,SW=3), both with FRAME_LEN=4.
module tb_bmc_soft_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        h_valid = 1'b0, h_ready, h_sync = 1'b0, h_ov, h_or = 1'b1, h_last;
    logic [1:0]  h_sym = '0, h_erase = '0;
    logic [7:0]  h_bm;

    logic        s_valid = 1'b0, s_ready, s_sync = 1'b0, s_ov, s_or = 1'b1, s_last;
    logic [5:0]  s_sym = '0;
    logic [1:0]  s_erase = '0;
    logic [15:0] s_bm;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bmc_soft_pipe #(.N(2), .SW(1), .FRAME_LEN(4)) u_hard (
        .clk(clk), .rst(rst), .in_valid(h_valid), .in_ready(h_ready), .in_sym(h_sym),
`ifdef BMC_ERASURE_EN
        .in_erase(h_erase),
`endif
        .in_sync(h_sync), .out_valid(h_ov), .out_ready(h_or), .out_bm(h_bm), .out_last(h_last)
    );

    bmc_soft_pipe #(.N(2), .SW(3), .FRAME_LEN(4)) u_soft (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_ready), .in_sym(s_sym),
`ifdef BMC_ERASURE_EN
        .in_erase(s_erase),
`endif
        .in_sync(s_sync), .out_valid(s_ov), .out_ready(s_or), .out_bm(s_bm), .out_last(s_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference metric from the definition: d(j,0)=s, d(j,1)=7-s, erased fields give 0.
    function automatic logic [15:0] soft_bm(input logic [5:0] sym, input logic [1:0] er);
        logic [15:0] r;
        logic [3:0]  a, b;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a = ((c & 1) != 0) ? 4'(3'd7 - sym[2:0]) : 4'(sym[2:0]);
            b = ((c & 2) != 0) ? 4'(3'd7 - sym[5:3]) : 4'(sym[5:3]);
            if (er[0]) a = '0;
            if (er[1]) b = '0;
            r[c*4 +: 4] = a + b;
        end
        return r;
    endfunction

    function automatic logic [5:0] sym_of(input int k);
        logic [2:0] s0, s1;
        s0 = 3'(k);
        s1 = 3'(k * 5 + 2);
        return {s1, s0};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        h_valid = 1'b0; s_valid = 1'b0; h_sync = 1'b0; s_sync = 1'b0;
        h_or = 1'b1; s_or = 1'b1; s_erase = '0; h_erase = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Back-to-back stream of n symbols into the soft instance with out_ready held high.
    task automatic run_stream(input string tag, input int n, input int k0,
                              input logic [15:0] sync_m, input logic [15:0] last_m);
        for (int t = 0; t < n + 2; t++) begin
            @(negedge clk);
            if (t >= 2) begin
                chk({tag, "_ov"}, 32'(s_ov), 32'd1);
                chk({tag, "_bm"}, 32'(s_bm), 32'(soft_bm(sym_of(k0 + t - 2), 2'b00)));
                chk({tag, "_last"}, 32'(s_last), 32'(last_m[t-2]));
            end
            if (t < n) begin
                s_valid = 1'b1; s_sym = sym_of(k0 + t); s_sync = sync_m[t];
            end else begin
                s_valid = 1'b0; s_sync = 1'b0;
            end
        end
    endtask

    logic [7:0]  exp_h [4] = '{8'h94, 8'h61, 8'h49, 8'h16};
    logic [15:0] held;
    int          k, got;

    initial begin
        // Reset state
        #3;
        chk("rst_h_ov", 32'(h_ov), 32'd0);
        chk("rst_h_bm", 32'(h_bm), 32'd0);
        chk("rst_s_ov", 32'(s_ov), 32'd0);
        chk("rst_s_last", 32'(s_last), 32'd0);
        chk("rst_s_bm", 32'(s_bm), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_h_ready", 32'(h_ready), 32'd1);
        chk("rel_s_ready", 32'(s_ready), 32'd1);

        // Hard-decision table: rx 00,01,10,11 back-to-back
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk("hard_ov", 32'(h_ov), 32'd1);
                chk("hard_bm", 32'(h_bm), 32'(exp_h[i-2]));
            end
            h_valid = (i < 4);
            h_sym   = 2'(i);
        end
        @(negedge clk);
        chk("hard_drain", 32'(h_ov), 32'd0);

        // Soft directed vectors: {6,1} then all-7
        do_reset();
        @(negedge clk); s_valid = 1'b1; s_sym = {3'd6, 3'd1};
        @(negedge clk); s_sym = {3'd7, 3'd7};
        @(negedge clk); s_valid = 1'b0;
        chk("soft_61", 32'(s_bm), 32'h72C7);
        @(negedge clk);
        chk("soft_77", 32'(s_bm), 32'h077E);

`ifdef BMC_ERASURE_EN
        do_reset();
        @(negedge clk); s_valid = 1'b1; s_sym = {3'd5, 3'd2}; s_erase = 2'b10;
        @(negedge clk); s_valid = 1'b0; s_erase = 2'b00;
        @(negedge clk);
        chk("erase_ov", 32'(s_ov), 32'd1);
        chk("erase_bm", 32'(s_bm), 32'h5252);
`endif

        // Back-pressure: out_ready low on cycles 4..7, 12 symbols
        do_reset();
        k = 0; got = 0; held = '0;
        for (int t = 0; t < 40 && got < 12; t++) begin
            @(negedge clk);
            s_or    = !(t >= 4 && t <= 7);
            s_valid = (k < 12);
            s_sym   = sym_of(k);
            #1;
            if (t == 4) begin
                chk("bp_in_ready", 32'(s_ready), 32'd0);
                held = s_bm;
            end
            if (t > 4 && t <= 7) chk("bp_hold", 32'(s_bm), 32'(held));
            if (s_ov && s_or) begin
                chk("bp_bm", 32'(s_bm), 32'(soft_bm(sym_of(got), 2'b00)));
                chk("bp_last", 32'(s_last), 32'((got % 4) == 3));
                got++;
            end
            if (t == 10) chk("bp_resume", 32'(got), 32'd5);
            if (s_valid && s_ready) k++;
        end
        chk("bp_count", 32'(got), 32'd12);
        @(negedge clk); s_valid = 1'b0; s_or = 1'b1;

        // Frame tagging: 10 symbols, sync on symbol 6
        do_reset();
        run_stream("frame", 10, 0, 16'h0040, 16'h0208);

        // Sync on the wrap symbol takes index 0 and is not last
        do_reset();
        run_stream("wrap", 8, 3, 16'h0008, 16'h0040);

        // Sync without accept is ignored
        do_reset();
        run_stream("ign_a", 2, 1, 16'h0000, 16'h0000);
        @(negedge clk); s_sync = 1'b1; s_valid = 1'b0;
        run_stream("ign_b", 2, 5, 16'h0000, 16'h0002);

        // Reset with two symbols in flight
        do_reset();
        @(negedge clk); s_valid = 1'b1; s_sym = sym_of(2);
        @(negedge clk); s_sym = sym_of(3);
        @(negedge clk); s_valid = 1'b0;
        chk("mid_pre_ov", 32'(s_ov), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("mid_async_ov", 32'(s_ov), 32'd0);
        chk("mid_async_bm", 32'(s_bm), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_stale", 32'(s_ov), 32'd0);
        end
        run_stream("mid_frame", 4, 4, 16'h0000, 16'h0008);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bmc_soft_pipe.md
Name: bmc_soft_pipe

Overview:
- Parametrised branch-metric unit for the Viterbi decoder datapath, for rate-1/N codes.
- Per received symbol, computes the metric for every one of the 2^N candidate codewords; hard or soft decision.
- Two-stage pipeline with valid/ready handshake on both sides, and a frame position counter that tags the last symbol of each frame for the ACS/traceback stages downstream.
- Defaults (N=2, SW=1) give the classic 2-bit Hamming metrics.

Parameters:
- N, 2, code outputs per symbol (rate 1/N); legal range 2..4
- SW, 1, bits per received sample; 1 = hard decision, >1 = unsigned soft confidence (0 = strong 0, 2^SW-1 = strong 1)
- FRAME_LEN, 64, symbols per frame; legal range ≥2
- MW, derived = SW + clog2(N), metric width; not overridable

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  input symbol valid
- in_ready  out  1  block can accept a symbol
- in_sym  in  N*SW  received samples; field j = in_sym[j*SW +: SW]
- in_sync  in  1  qualified by accept; forces this symbol to frame index 0
- out_valid  out  1  metrics valid
- out_ready  in  1  downstream accepts
- out_bm  out  (2^N)*MW  metric for codeword c in out_bm[c*MW +: MW]
- out_last  out  1  out_bm belongs to frame index FRAME_LEN-1

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-low. While rst=0, every register clears: s1_valid, s2_valid, out_valid, out_last, out_bm = 0, and frame counter = 0. in_ready is 1 one cycle after release.
- Accept and transfer events: accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Per-sample distances: d(j,0) = sample_j and d(j,1) = (2^SW-1) - sample_j.
  - Stage 1 registers both distances for every field j, plus the frame tag.
- Metric sum: BM[c] = sum over j of d(j, c[j]), where c[j] is the expected bit for field j.
  - Computed into stage 2, width MW. No overflow is possible, so no saturation.
  - Example: N=2, SW=1, rx=2'b01 gives BM = {00:1, 01:0, 10:2, 11:1}.
- Latency: 2 cycles from accept to out_valid when there is no back-pressure. Throughput is 1 symbol per cycle.
- Stall rules:
  - s2_load = !s2_valid | out_ready
  - s1_load = !s1_valid | s2_load
  - in_ready = s1_load (combinational path from out_ready is permitted)
  - While a stage holds, its contents stay stable. out_bm and out_last do not change while out_valid & !out_ready.
- Bubbles: a stage whose predecessor is empty loads valid=0. Bubbles collapse. No symbol is dropped or duplicated.
- Frame counter: fcnt counts accepted symbols 0..FRAME_LEN-1 and wraps to 0.
  - The tag last = (idx == FRAME_LEN-1), where idx = in_sync ? 0 : fcnt.
  - On accept, fcnt <= (idx == FRAME_LEN-1) ? 0 : idx+1.
  - The tag travels with the symbol to out_last.
- in_sync boundary case: when in_sync arrives on the same cycle as the wrap, the symbol takes index 0 and last=0.
- Ignored inputs: in_sync without accept is ignored. in_sym is ignored without accept.
- Reset mid-frame: discards in-flight symbols and restarts the frame at index 0.
- Fixed output ordering: out_bm index order is fixed regardless of N. Unused upper bits do not exist (width is exact).

Optional Feature:
- Macro BMC_ERASURE_EN. When defined, adds port in_erase (in, N bits) for depunctured symbols.
  - If in_erase[j]=1, d(j,0) = d(j,1) = 0. That field contributes nothing to any BM[c].
  - The erase mask is pipelined alongside in_sym.
- When not defined, the port is absent and all fields always contribute.

Decomposition:
- Package bmc_pkg holds:
  - clog2-based MW function
  - hard-decision maximum-confidence constant
  - an enum for metric mode (HARD/SOFT), derived from SW
- Sub-module bmc_dist computes d(j,0)/d(j,1) for one field (plus erase gating). It is instantiated N times in stage 1.
- The pipeline, handshake and frame counter stay in the top module.

Test Plan:
- Hard-decision table: N=2, SW=1, out_ready=1. Stream rx = 00, 01, 10, 11 back-to-back.
  - Cycles 2..5 give BM[00..11] = {0,1,1,2}, {1,0,2,1}, {1,2,0,1}, {2,1,1,0}.
  - out_valid is continuous.
- Soft metrics: N=2, SW=3. rx = {s1=6, s0=1}.
  - BM[00]=7, BM[01]=12, BM[10]=2, BM[11]=7 (c bit 0 ↔ field 0).
  - All-7 input gives BM[11]=0 and BM[00]=14.
- Back-pressure: continuous input, out_ready low for cycles 4..7.
  - in_ready drops within 1 cycle. Held out_bm is stable.
  - All symbols are delivered in order with none lost; stall is released with 1/cycle resume.
- Frame tagging: FRAME_LEN=4, 10 symbols accepted, with in_sync on symbol 6.
  - out_last is set on symbols 3 and 9 only.
  - Symbol 6 starts a new frame (indices 0..3 for symbols 6..9).
- Reset mid-operation: assert rst with 2 symbols in flight.
  - out_valid=0 immediately (async). No stale output after release.
  - The next frame starts at index 0.
- Erasure (BMC_ERASURE_EN): N=2, SW=3, rx={5,2}, erase=2'b10.
  - BM[00]=BM[10]=2, BM[01]=BM[11]=5.
